// File: rtl/superh16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : superh16_pkg
// Purpose  : Shared core types and constants (uop encodings, ROB/tag widths,
//            divide sequencer state and latency).
// Revision : 1.0 - initial release
// ============================================================================
package superh16_pkg;

  localparam int XLEN          = 64;
  localparam int ROB_ENTRIES   = 240;
  localparam int ROB_IDX_BITS  = 8;
  localparam int PHYS_REG_BITS = 10;

  // Must stay equal to the divide entry of get_exec_latency.
  localparam int DIV_LATENCY   = 12;

  typedef enum logic [6:0] {
    UOP_DIV  = 7'd14,
    UOP_DIVU = 7'd15,
    UOP_REM  = 7'd16,
    UOP_REMU = 7'd17
  } uop_opcode_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  function automatic logic is_div_op(input logic [6:0] op);
    return (op == UOP_DIV) || (op == UOP_DIVU) || (op == UOP_REM) || (op == UOP_REMU);
  endfunction

endpackage : superh16_pkg
`default_nettype wire

// File: rtl/superh16_div_calc.sv
`default_nettype none
// ============================================================================
// Module   : superh16_div_calc
// Purpose  : Combinational RISC-V DIV/DIVU/REM/REMU with divide-by-zero and
//            signed-overflow semantics.
// Revision : 1.0 - initial release
// ============================================================================
module superh16_div_calc #(
  parameter int XLEN = superh16_pkg::XLEN
) (
  input  logic [6:0]      opcode,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic [XLEN-1:0] result
);
  import superh16_pkg::*;

  logic            is_signed;
  logic            is_quot;
  logic            div_zero;
  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] safe_b;
  logic [XLEN-1:0] uquot;
  logic [XLEN-1:0] urem;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] rem;

  // One unsigned divider on magnitudes; -2^63 / -1 falls out naturally
  // (|-2^63| = 2^63, quotient 2^63 reinterpreted is -2^63, remainder 0).
  always_comb begin
    is_signed = (opcode == UOP_DIV) || (opcode == UOP_REM);
    is_quot   = (opcode == UOP_DIV) || (opcode == UOP_DIVU);
    div_zero  = (src2 == '0);
    neg_a     = is_signed & src1[XLEN-1];
    neg_b     = is_signed & src2[XLEN-1];
    mag_a     = neg_a ? (~src1 + 1'b1) : src1;
    mag_b     = neg_b ? (~src2 + 1'b1) : src2;
    safe_b    = div_zero ? {{(XLEN-1){1'b0}}, 1'b1} : mag_b;
    uquot     = mag_a / safe_b;
    urem      = mag_a % safe_b;
    quot      = (neg_a ^ neg_b) ? (~uquot + 1'b1) : uquot;
    rem       = neg_a ? (~urem + 1'b1) : urem;
    if (div_zero) begin
      quot = '1;
      rem  = src1;
    end
    result = is_quot ? quot : rem;
  end

endmodule : superh16_div_calc
`default_nettype wire

// File: rtl/superh16_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : superh16_div_sequencer
// Purpose  : Oldest-first sharing of the single divide resource among issue
//            ports, fixed-latency hold, valid/ready writeback, flush kill.
//            Optional: SUPERH16_DIV_EARLY_WAKEUP_EN (wakeup one cycle early).
// Revision : 1.0 - initial release
// ============================================================================
module superh16_div_sequencer #(
  parameter int NUM_REQ       = 3,
  parameter int DIV_LATENCY   = superh16_pkg::DIV_LATENCY,
  parameter int XLEN          = superh16_pkg::XLEN,
  parameter int ROB_ENTRIES   = superh16_pkg::ROB_ENTRIES,
  parameter int ROB_IDX_BITS  = superh16_pkg::ROB_IDX_BITS,
  parameter int PHYS_REG_BITS = superh16_pkg::PHYS_REG_BITS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*7-1:0]              req_opcode,
  input  logic [NUM_REQ*XLEN-1:0]           req_src1,
  input  logic [NUM_REQ*XLEN-1:0]           req_src2,
  input  logic [NUM_REQ*PHYS_REG_BITS-1:0]  req_dst_tag,
  input  logic [NUM_REQ*ROB_IDX_BITS-1:0]   req_rob_idx,
  input  logic [ROB_IDX_BITS-1:0]           rob_head,
  input  logic                              flush_valid,
  input  logic [ROB_IDX_BITS-1:0]           flush_rob_idx,
  output logic                              div_busy,
  output logic                              wb_valid,
  input  logic                              wb_ready,
  output logic [PHYS_REG_BITS-1:0]          wb_dst_tag,
  output logic [ROB_IDX_BITS-1:0]           wb_rob_idx,
  output logic [XLEN-1:0]                   wb_result,
  output logic                              wakeup_valid,
  output logic [PHYS_REG_BITS-1:0]          wakeup_tag
);
  import superh16_pkg::*;

  localparam int                    OPC_W    = 7;
  localparam int                    CNT_W    = $clog2(DIV_LATENCY);
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(DIV_LATENCY - 2);
  localparam logic [ROB_IDX_BITS:0] ROB_SIZE = (ROB_IDX_BITS+1)'(ROB_ENTRIES);

  function automatic logic [ROB_IDX_BITS-1:0] age_of(input logic [ROB_IDX_BITS-1:0] idx,
                                                      input logic [ROB_IDX_BITS-1:0] head);
    logic [ROB_IDX_BITS:0] diff;
    diff = {1'b0, idx} - {1'b0, head};
    if (idx < head) diff = diff + ROB_SIZE;
    return diff[ROB_IDX_BITS-1:0];
  endfunction

  div_state_t               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [PHYS_REG_BITS-1:0] tag_q, tag_d;
  logic [ROB_IDX_BITS-1:0]  rob_q, rob_d;
  logic [XLEN-1:0]          result_q, result_d;

  logic [ROB_IDX_BITS-1:0]  port_age [NUM_REQ];
  logic [ROB_IDX_BITS-1:0]  best_age;
  logic                     found;
  logic [NUM_REQ-1:0]       grant_oh;
  logic [OPC_W-1:0]         sel_opcode;
  logic [XLEN-1:0]          sel_src1;
  logic [XLEN-1:0]          sel_src2;
  logic [PHYS_REG_BITS-1:0] sel_tag;
  logic [ROB_IDX_BITS-1:0]  sel_rob;
  logic [XLEN-1:0]          calc_result;
  logic                     accept;
  logic                     kill;
  logic [ROB_IDX_BITS-1:0]  held_age;
  logic [ROB_IDX_BITS-1:0]  flush_age;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_age
      assign port_age[gi] = age_of(req_rob_idx[gi*ROB_IDX_BITS +: ROB_IDX_BITS], rob_head);
    end
  endgenerate

  // Strict '<' while scanning upward keeps ties on the lowest port.
  always_comb begin
    found      = 1'b0;
    best_age   = '0;
    grant_oh   = '0;
    sel_opcode = '0;
    sel_src1   = '0;
    sel_src2   = '0;
    sel_tag    = '0;
    sel_rob    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && (!found || (port_age[i] < best_age))) begin
        found       = 1'b1;
        best_age    = port_age[i];
        grant_oh    = '0;
        grant_oh[i] = 1'b1;
        sel_opcode  = req_opcode[i*OPC_W +: OPC_W];
        sel_src1    = req_src1[i*XLEN +: XLEN];
        sel_src2    = req_src2[i*XLEN +: XLEN];
        sel_tag     = req_dst_tag[i*PHYS_REG_BITS +: PHYS_REG_BITS];
        sel_rob     = req_rob_idx[i*ROB_IDX_BITS +: ROB_IDX_BITS];
      end
    end
    req_ready = ((state_q == DIV_IDLE) && !flush_valid) ? grant_oh : '0;
  end

  superh16_div_calc #(
    .XLEN (XLEN)
  ) u_div_calc (
    .opcode (sel_opcode),
    .src1   (sel_src1),
    .src2   (sel_src2),
    .result (calc_result)
  );

  assign accept    = |req_ready;
  assign held_age  = age_of(rob_q, rob_head);
  assign flush_age = age_of(flush_rob_idx, rob_head);
  assign kill      = flush_valid && (state_q != DIV_IDLE) && (held_age > flush_age);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    rob_d    = rob_q;
    result_d = result_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          state_d  = DIV_BUSY;
          cnt_d    = CNT_LOAD;
          tag_d    = sel_tag;
          rob_d    = sel_rob;
          result_d = calc_result;
        end
      end
      DIV_BUSY: begin
        if (cnt_q == '0) state_d = DIV_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DIV_DONE: begin
        if (wb_ready) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
    // A kill overrides any writeback handshake in the same cycle.
    if (kill) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      tag_q    <= '0;
      rob_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tag_q    <= tag_d;
      rob_q    <= rob_d;
      result_q <= result_d;
    end
  end

  assign div_busy   = (state_q != DIV_IDLE);
  assign wb_valid   = (state_q == DIV_DONE);
  assign wb_dst_tag = tag_q;
  assign wb_rob_idx = rob_q;
  assign wb_result  = result_q;

`ifdef SUPERH16_DIV_EARLY_WAKEUP_EN
  assign wakeup_valid = (state_q == DIV_BUSY) && (cnt_q == '0) && !kill;
  assign wakeup_tag   = wakeup_valid ? tag_q : '0;
`else
  assign wakeup_valid = 1'b0;
  assign wakeup_tag   = '0;
`endif

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_opcode_chk
      a_div_opcode : assert property (@(posedge clk) disable iff (!rst_n)
        req_valid[gi] |-> is_div_op(req_opcode[gi*OPC_W +: OPC_W]));
    end
  endgenerate

endmodule : superh16_div_sequencer
`default_nettype wire

// File: tb/tb_superh16_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_superh16_div_sequencer
// Purpose  : Directed self-checking bench for superh16_div_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_superh16_div_sequencer;

  localparam int NR = 3;
  localparam int XL = 64;
  localparam int RB = 8;
  localparam int PT = 10;

  localparam logic [6:0] OP_DIV  = 7'd14;
  localparam logic [6:0] OP_DIVU = 7'd15;
  localparam logic [6:0] OP_REM  = 7'd16;
  localparam logic [6:0] OP_REMU = 7'd17;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*7-1:0]   req_opcode = '0;
  logic [NR*XL-1:0]  req_src1 = '0;
  logic [NR*XL-1:0]  req_src2 = '0;
  logic [NR*PT-1:0]  req_dst_tag = '0;
  logic [NR*RB-1:0]  req_rob_idx = '0;
  logic [RB-1:0]     rob_head = '0;
  logic              flush_valid = 1'b0;
  logic [RB-1:0]     flush_rob_idx = '0;
  logic              div_busy;
  logic              wb_valid;
  logic              wb_ready = 1'b0;
  logic [PT-1:0]     wb_dst_tag;
  logic [RB-1:0]     wb_rob_idx;
  logic [XL-1:0]     wb_result;
  logic              wakeup_valid;
  logic [PT-1:0]     wakeup_tag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  superh16_div_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_opcode    (req_opcode),
    .req_src1      (req_src1),
    .req_src2      (req_src2),
    .req_dst_tag   (req_dst_tag),
    .req_rob_idx   (req_rob_idx),
    .rob_head      (rob_head),
    .flush_valid   (flush_valid),
    .flush_rob_idx (flush_rob_idx),
    .div_busy      (div_busy),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_dst_tag    (wb_dst_tag),
    .wb_rob_idx    (wb_rob_idx),
    .wb_result     (wb_result),
    .wakeup_valid  (wakeup_valid),
    .wakeup_tag    (wakeup_tag)
  );

  task automatic set_req(input int p, input logic [6:0] op, input logic [XL-1:0] a,
                         input logic [XL-1:0] b, input logic [PT-1:0] tg, input logic [RB-1:0] rb);
    req_valid[p]            = 1'b1;
    req_opcode[p*7 +: 7]    = op;
    req_src1[p*XL +: XL]    = a;
    req_src2[p*XL +: XL]    = b;
    req_dst_tag[p*PT +: PT] = tg;
    req_rob_idx[p*RB +: RB] = rb;
  endtask

  // Called in the accept cycle; steps to the first wb_valid (bounded), captures
  // the writeback, completes the handshake and returns in the following cycle.
  task automatic drain(input logic [NR-1:0] drop, output int lat, output logic [XL-1:0] res,
                       output logic [PT-1:0] tg, output logic [RB-1:0] rb);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) req_valid = req_valid & ~drop;
    end while (!wb_valid && lat < 40);
    res = wb_result;
    tg  = wb_dst_tag;
    rb  = wb_rob_idx;
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (req_ready !== '0 || div_busy !== 1'b0 || wb_valid !== 1'b0 || wb_result !== '0 ||
        wb_dst_tag !== '0 || wb_rob_idx !== '0 || wakeup_valid !== 1'b0 || wakeup_tag !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b wb_valid=%b result=%h tag=%0d rob=%0d required all zero",
               div_busy, wb_valid, wb_result, wb_dst_tag, wb_rob_idx);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (div_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: div_busy=%b required 0", div_busy);
    end
  endtask

  task automatic test_basic();
    logic exp_wk;
    @(negedge clk);
    rob_head = 8'd0;
    set_req(0, OP_DIV, 64'd100, 64'd7, 10'd40, 8'd5);
    #1;
    n_checks++;
    if (req_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL basic_grant: req_ready=%b required 001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    for (int k = 1; k < 12; k++) begin
      exp_wk = 1'b0;
`ifdef SUPERH16_DIV_EARLY_WAKEUP_EN
      exp_wk = (k == 11);
`endif
      n_checks++;
      if (wb_valid !== 1'b0 || div_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_busy_c%0d: wb_valid=%b div_busy=%b required 0/1", k, wb_valid, div_busy);
      end
      n_checks++;
      if (wakeup_valid !== exp_wk) begin
        n_fail++;
        $display("FAIL basic_wakeup_c%0d: wakeup_valid=%b required %b", k, wakeup_valid, exp_wk);
      end
      @(negedge clk);
    end
    n_checks++;
    if (wb_valid !== 1'b1 || wb_result !== 64'd14 || wb_dst_tag !== 10'd40 || wb_rob_idx !== 8'd5) begin
      n_fail++;
      $display("FAIL basic_wb: valid=%b result=%0d tag=%0d rob=%0d required 1/14/40/5",
               wb_valid, wb_result, wb_dst_tag, wb_rob_idx);
    end
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    n_checks++;
    if (wb_valid !== 1'b0 || div_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle_after_wb: wb_valid=%b div_busy=%b required 0/0", wb_valid, div_busy);
    end
  endtask

  task automatic test_age_order();
    int             lat;
    logic [XL-1:0]  res;
    logic [PT-1:0]  tg;
    logic [RB-1:0]  rb;
    @(negedge clk);
    rob_head = 8'd230;
    set_req(0, OP_DIVU, 64'd20, 64'd4, 10'd11, 8'd2);    // age 12
    set_req(1, OP_DIVU, 64'd30, 64'd3, 10'd12, 8'd235);  // age 5
    set_req(2, OP_DIVU, 64'd81, 64'd9, 10'd13, 8'd238);  // age 8
    #1;
    n_checks++;
    if (req_ready !== 3'b010) begin
      n_fail++;
      $display("FAIL age_grant1: req_ready=%b required 010", req_ready);
    end
    drain(3'b010, lat, res, tg, rb);
    n_checks++;
    if (lat !== 12 || res !== 64'd10 || tg !== 10'd12 || rb !== 8'd235) begin
      n_fail++;
      $display("FAIL age_wb1: lat=%0d result=%0d tag=%0d rob=%0d required 12/10/12/235", lat, res, tg, rb);
    end
    n_checks++;
    if (req_ready !== 3'b100) begin
      n_fail++;
      $display("FAIL age_grant2: req_ready=%b required 100", req_ready);
    end
    drain(3'b100, lat, res, tg, rb);
    n_checks++;
    if (lat !== 12 || res !== 64'd9 || tg !== 10'd13 || rb !== 8'd238) begin
      n_fail++;
      $display("FAIL age_wb2: lat=%0d result=%0d tag=%0d rob=%0d required 12/9/13/238", lat, res, tg, rb);
    end
    n_checks++;
    if (req_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL age_grant3: req_ready=%b required 001", req_ready);
    end
    drain(3'b001, lat, res, tg, rb);
    n_checks++;
    if (lat !== 12 || res !== 64'd5 || tg !== 10'd11 || rb !== 8'd2) begin
      n_fail++;
      $display("FAIL age_wb3: lat=%0d result=%0d tag=%0d rob=%0d required 12/5/11/2", lat, res, tg, rb);
    end
  endtask

  typedef struct {
    logic [6:0]    op;
    logic [XL-1:0] a;
    logic [XL-1:0] b;
    logic [XL-1:0] exp;
  } vec_t;

  task automatic test_corner_cases();
    vec_t           vecs [6];
    int             lat;
    logic [XL-1:0]  res;
    logic [PT-1:0]  tg;
    logic [RB-1:0]  rb;
    vecs[0] = '{OP_DIVU, 64'h1234,                64'd0,                  64'hFFFF_FFFF_FFFF_FFFF};
    vecs[1] = '{OP_REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd0,                  64'hFFFF_FFFF_FFFF_FFF9};
    vecs[2] = '{OP_DIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
    vecs[3] = '{OP_REM,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
    vecs[4] = '{OP_DIV,  64'hFFFF_FFFF_FFFF_FFEC, 64'd3,                  64'hFFFF_FFFF_FFFF_FFFA};
    vecs[5] = '{OP_REMU, 64'd20,                  64'd3,                  64'd2};
    rob_head = 8'd0;
    for (int i = 0; i < 6; i++) begin
      set_req(0, vecs[i].op, vecs[i].a, vecs[i].b, PT'(20 + i), RB'(i));
      #1;
      drain(3'b001, lat, res, tg, rb);
      n_checks++;
      if (lat !== 12 || res !== vecs[i].exp) begin
        n_fail++;
        $display("FAIL corner_%0d: lat=%0d result=%h required lat 12 result %h", i, lat, res, vecs[i].exp);
      end
    end
  endtask

  task automatic test_backpressure();
    int             lat;
    logic [XL-1:0]  res;
    logic [PT-1:0]  tg;
    logic [RB-1:0]  rb;
    rob_head = 8'd0;
    set_req(0, OP_DIV, 64'd50, 64'd5, 10'd7, 8'd3);
    #1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        req_valid = '0;
        set_req(1, OP_REMU, 64'd17, 64'd5, 10'd8, 8'd4);
      end
    end while (!wb_valid && lat < 40);
    n_checks++;
    if (lat !== 12) begin
      n_fail++;
      $display("FAIL bp_latency: lat=%0d required 12", lat);
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (wb_valid !== 1'b1 || wb_result !== 64'd10 || wb_dst_tag !== 10'd7 || wb_rob_idx !== 8'd3 ||
          div_busy !== 1'b1 || req_ready !== 3'b000) begin
        n_fail++;
        $display("FAIL bp_hold_c%0d: valid=%b result=%0d tag=%0d rob=%0d busy=%b ready=%b required 1/10/7/3/1/000",
                 k, wb_valid, wb_result, wb_dst_tag, wb_rob_idx, div_busy, req_ready);
      end
      @(negedge clk);
    end
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    #1;
    n_checks++;
    if (wb_valid !== 1'b0 || req_ready !== 3'b010) begin
      n_fail++;
      $display("FAIL bp_next_grant: wb_valid=%b req_ready=%b required 0/010", wb_valid, req_ready);
    end
    drain(3'b010, lat, res, tg, rb);
    n_checks++;
    if (lat !== 12 || res !== 64'd2 || tg !== 10'd8) begin
      n_fail++;
      $display("FAIL bp_second_wb: lat=%0d result=%0d tag=%0d required 12/2/8", lat, res, tg);
    end
  endtask

  task automatic test_flush();
    int   lat;
    logic seen;
    rob_head = 8'd0;
    set_req(0, OP_DIVU, 64'd90, 64'd9, 10'd21, 8'd10);
    flush_valid   = 1'b1;
    flush_rob_idx = 8'd0;
    #1;
    n_checks++;
    if (req_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL flush_blocks_grant: req_ready=%b required 000", req_ready);
    end
    flush_valid = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL flush_grant: req_ready=%b required 001", req_ready);
    end
    seen = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = '0;
      if (k == 6) begin
        flush_valid   = 1'b1;
        flush_rob_idx = 8'd4;
      end else begin
        flush_valid = 1'b0;
      end
      if (k == 7) begin
        n_checks++;
        if (div_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL flush_kill_idle: div_busy=%b required 0", div_busy);
        end
      end
      if (wb_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_kill_no_wb: wb_valid seen=%b required 0", seen);
    end
    set_req(0, OP_DIVU, 64'd90, 64'd9, 10'd21, 8'd10);
    #1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) req_valid = '0;
      if (lat == 6) begin
        flush_valid   = 1'b1;
        flush_rob_idx = 8'd12;
      end else begin
        flush_valid = 1'b0;
      end
    end while (!wb_valid && lat < 40);
    n_checks++;
    if (lat !== 12 || wb_result !== 64'd10 || wb_dst_tag !== 10'd21) begin
      n_fail++;
      $display("FAIL flush_older_survives: lat=%0d result=%0d tag=%0d required 12/10/21", lat, wb_result, wb_dst_tag);
    end
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    int             lat;
    logic [XL-1:0]  res;
    logic [PT-1:0]  tg;
    logic [RB-1:0]  rb;
    rob_head = 8'd0;
    set_req(0, OP_DIV, 64'd9, 64'd3, 10'd33, 8'd1);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== '0 || div_busy !== 1'b0 || wb_valid !== 1'b0 || wb_result !== '0 ||
        wb_dst_tag !== '0 || wb_rob_idx !== '0 || wakeup_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b wb_valid=%b result=%h tag=%0d rob=%0d required all zero",
               div_busy, wb_valid, wb_result, wb_dst_tag, wb_rob_idx);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_req(0, OP_DIV, 64'd1000, 64'd10, 10'd44, 8'd2);
    #1;
    drain(3'b001, lat, res, tg, rb);
    n_checks++;
    if (lat !== 12 || res !== 64'd100 || tg !== 10'd44 || rb !== 8'd2) begin
      n_fail++;
      $display("FAIL post_reset_op: lat=%0d result=%0d tag=%0d rob=%0d required 12/100/44/2", lat, res, tg, rb);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_age_order();
    test_corner_cases();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_superh16_div_sequencer
`default_nettype wire
